// File: rtl/mips_cpu_multicycle.sv
// Multi-cycle MIPS32-subset CPU: six-state control FSM around a shared byte-wide,
// big-endian memory and a 32-entry register file. No data ports.
module mips_cpu_multicycle #(
    parameter int    MEM_BYTES = 512,
    parameter string MEM_FILE  = "program.txt"
) (
    input  logic clk,
    input  logic reset
);

    localparam int AW = $clog2(MEM_BYTES);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        LOADIR = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] npc;
    logic [31:0] mar;
    logic [31:0] mdr;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_aluout;
    logic [31:0] rf  [0:31];
    logic [7:0]  mem [0:MEM_BYTES-1];

    logic [5:0]    w_op;
    logic [4:0]    w_rs;
    logic [4:0]    w_rt;
    logic [4:0]    w_rd;
    logic [5:0]    w_funct;
    logic [31:0]   w_simm;
    logic [31:0]   w_zimm;
    logic          w_is_rtype;
    logic          w_is_ialu;
    logic          w_is_lw;
    logic          w_is_sw;
    logic [31:0]   w_alu;
    logic [AW-1:0] w_idx0;
    logic [AW-1:0] w_idx1;
    logic [AW-1:0] w_idx2;
    logic [AW-1:0] w_idx3;
    logic [31:0]   w_mem_rd;
    logic          w_unused;

    assign w_op    = ir[31:26];
    assign w_rs    = ir[25:21];
    assign w_rt    = ir[20:16];
    assign w_rd    = ir[15:11];
    assign w_funct = ir[5:0];
    assign w_simm  = {{16{ir[15]}}, ir[15:0]};
    assign w_zimm  = {16'h0, ir[15:0]};
    assign w_is_lw = (w_op == OP_LW);
    assign w_is_sw = (w_op == OP_SW);

    // Word access ignores addr[1:0]; high address bits wrap modulo MEM_BYTES.
    assign w_idx0   = {mar[AW-1:2], 2'b00};
    assign w_idx1   = {mar[AW-1:2], 2'b01};
    assign w_idx2   = {mar[AW-1:2], 2'b10};
    assign w_idx3   = {mar[AW-1:2], 2'b11};
    assign w_mem_rd = {mem[w_idx0], mem[w_idx1], mem[w_idx2], mem[w_idx3]};
    assign w_unused = &{1'b0, mar[31:AW], mar[1:0], ir[10:6]};

    // ALU result plus a flag saying whether the opcode/funct is an ALU op at all;
    // unknown encodings leave both flags low and fall through as NOPs.
    always_comb begin
        w_alu      = '0;
        w_is_rtype = 1'b0;
        w_is_ialu  = 1'b0;
        if (w_op == OP_RTYPE) begin
            w_is_rtype = 1'b1;
            case (w_funct)
                FN_ADDU: w_alu = r_a + r_b;
                FN_SUBU: w_alu = r_a - r_b;
                FN_AND:  w_alu = r_a & r_b;
                FN_OR:   w_alu = r_a | r_b;
                FN_SLT:  w_alu = {31'h0, $signed(r_a) < $signed(r_b)};
                FN_SLTU: w_alu = {31'h0, r_a < r_b};
                default: w_is_rtype = 1'b0;
            endcase
        end else begin
            w_is_ialu = 1'b1;
            case (w_op)
                OP_ADDIU: w_alu = r_a + w_simm;
                OP_ANDI:  w_alu = r_a & w_zimm;
                OP_ORI:   w_alu = r_a | w_zimm;
                OP_SLTI:  w_alu = {31'h0, $signed(r_a) < $signed(w_simm)};
                OP_LUI:   w_alu = {ir[15:0], 16'h0};
                default:  w_is_ialu = 1'b0;
            endcase
        end
    end

    // Memory is never cleared by reset; a store is suppressed on a reset edge.
    always_ff @(posedge clk) begin
        if (!reset && state == MEM && w_is_sw) begin
            mem[w_idx0] <= r_b[31:24];
            mem[w_idx1] <= r_b[23:16];
            mem[w_idx2] <= r_b[15:8];
            mem[w_idx3] <= r_b[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            pc       <= '0;
            ir       <= '0;
            npc      <= '0;
            mar      <= '0;
            mdr      <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_aluout <= '0;
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else begin
            case (state)
                FETCH: begin
                    mar   <= pc;
                    state <= LOADIR;
                end
                LOADIR: begin
                    ir    <= w_mem_rd;
                    npc   <= pc + 32'd4;
                    pc    <= pc + 32'd4;
                    state <= DECODE;
                end
                DECODE: begin
                    r_a   <= rf[w_rs];
                    r_b   <= rf[w_rt];
                    state <= EXEC;
                end
                EXEC: begin
                    if (w_is_rtype || w_is_ialu) begin
                        r_aluout <= w_alu;
                        state    <= WB;
                    end else if (w_is_lw || w_is_sw) begin
                        mar   <= r_a + w_simm;
                        state <= MEM;
                    end else begin
                        if ((w_op == OP_BEQ && r_a == r_b) || (w_op == OP_BNE && r_a != r_b)) begin
                            pc <= npc + (w_simm << 2);
                        end else if (w_op == OP_J) begin
                            pc <= {npc[31:28], ir[25:0], 2'b00};
                        end
                        state <= FETCH;
                    end
                end
                MEM: begin
                    if (w_is_lw) begin
                        mdr   <= w_mem_rd;
                        state <= WB;
                    end else begin
                        state <= FETCH;
                    end
                end
                WB: begin
                    // rf[0] is only ever cleared, so $zero reads 0 without a read-side mux.
                    if (w_is_rtype) begin
                        if (w_rd != 5'd0) rf[w_rd] <= r_aluout;
                    end else if (w_is_ialu) begin
                        if (w_rt != 5'd0) rf[w_rt] <= r_aluout;
                    end else if (w_is_lw) begin
                        if (w_rt != 5'd0) rf[w_rt] <= mdr;
                    end
                    state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_multicycle.sv
// Directed bench for mips_cpu_multicycle: loads small programs into the internal
// memory, runs fixed cycle counts and checks architectural state.
module tb_mips_cpu_multicycle;

    logic clk = 1'b0;
    logic reset = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] prog [0:31];

    mips_cpu_multicycle #(.MEM_BYTES(512)) dut (
        .clk   (clk),
        .reset (reset)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_op(input int rs, input int rt, input int rd, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(fn)};
    endfunction

    function automatic logic [31:0] i_op(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] j_op(input int target);
        return {6'h02, 26'(target)};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 32; i++) prog[i] = 32'h0;
    endtask

    // Reset is raised before touching memory so the CPU cannot store concurrently.
    task automatic boot();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 512; i++) dut.mem[i] = 8'h00;
        for (int w = 0; w < 32; w++) begin
            dut.mem[4*w]   = prog[w][31:24];
            dut.mem[4*w+1] = prog[w][23:16];
            dut.mem[4*w+2] = prog[w][15:8];
            dut.mem[4*w+3] = prog[w][7:0];
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] mem_word(input int a);
        return {dut.mem[a], dut.mem[a+1], dut.mem[a+2], dut.mem[a+3]};
    endfunction

    initial begin
        logic [31:0] rf_or;

        // addu/subu with a negative immediate operand
        clear_prog();
        prog[0] = i_op(9, 0, 1, 5);
        prog[1] = i_op(9, 0, 2, -3);
        prog[2] = r_op(1, 2, 3, 'h21);
        prog[3] = r_op(1, 2, 4, 'h23);
        boot();
        run(20);
        chk("t2_r1", dut.rf[1], 32'd5);
        chk("t2_r2", dut.rf[2], 32'hFFFF_FFFD);
        chk("t2_r3", dut.rf[3], 32'd2);
        chk("t2_r4", dut.rf[4], 32'd8);
        chk("t2_pc", dut.pc, 32'd16);

        // one-edge reset after a program has dirtied the state
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        rf_or = 32'h0;
        for (int i = 0; i < 32; i++) rf_or = rf_or | dut.rf[i];
        chk("rst_pc", dut.pc, 32'h0);
        chk("rst_state", 32'(dut.state), 32'd0);
        chk("rst_rf", rf_or, 32'h0);
        chk("rst_ir", dut.ir, 32'h0);
        chk("rst_npc", dut.npc, 32'h0);
        chk("rst_mar", dut.mar, 32'h0);

        // lui/ori build a constant, store it and load it back
        clear_prog();
        prog[0] = i_op('h0F, 0, 5, 'h1234);
        prog[1] = i_op('h0D, 5, 5, 'h5678);
        prog[2] = i_op('h2B, 0, 5, 64);
        prog[3] = i_op('h23, 0, 6, 64);
        boot();
        run(21);
        chk("t3_r5", dut.rf[5], 32'h1234_5678);
        chk("t3_mem64", 32'(dut.mem[64]), 32'h12);
        chk("t3_mem67", 32'(dut.mem[67]), 32'h78);
        chk("t3_memw", mem_word(64), 32'h1234_5678);
        chk("t3_r6", dut.rf[6], 32'h1234_5678);
        chk("t3_pc", dut.pc, 32'd16);

        // signed vs unsigned compare, and writes to $zero
        clear_prog();
        prog[0] = i_op(9, 0, 1, 5);
        prog[1] = i_op(9, 0, 2, -3);
        prog[2] = r_op(2, 1, 7, 'h2A);
        prog[3] = r_op(2, 1, 8, 'h2B);
        prog[4] = i_op(9, 0, 0, 9);
        prog[5] = i_op('h0A, 2, 11, -2);
        boot();
        run(30);
        chk("t4_slt", dut.rf[7], 32'd1);
        chk("t4_sltu", dut.rf[8], 32'd0);
        chk("t4_zero", dut.rf[0], 32'd0);
        chk("t4_slti", dut.rf[11], 32'd1);

        // taken beq skips two, equal bne falls through, beq -1 self-loops
        clear_prog();
        prog[0] = i_op(9, 0, 1, 5);
        prog[1] = i_op(4, 1, 1, 2);
        prog[2] = i_op(9, 0, 9, 1);
        prog[3] = i_op(9, 0, 9, 2);
        prog[4] = i_op(5, 1, 1, 1);
        prog[5] = i_op(9, 0, 10, 7);
        prog[6] = i_op(4, 0, 0, -1);
        boot();
        run(18);
        chk("t5_skip", dut.rf[9], 32'd0);
        chk("t5_fall", dut.rf[10], 32'd7);
        chk("t5_pc_a", dut.pc, 32'd24);
        run(4);
        chk("t5_pc_b", dut.pc, 32'd24);
        chk("t5_state", 32'(dut.state), 32'd0);

        // jump
        clear_prog();
        prog[0] = j_op('h10);
        boot();
        run(4);
        chk("t6_j", dut.pc, 32'h40);

        // reset landing on the MEM cycle of a store must not write memory
        clear_prog();
        prog[0]  = i_op(9, 0, 1, 'h55);
        prog[1]  = i_op('h2B, 0, 1, 64);
        prog[16] = 32'hAAAA_AAAA;
        boot();
        run(9);
        chk("msw_in_mem", 32'(dut.state), 32'd4);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("msw_mem", mem_word(64), 32'hAAAA_AAAA);
        chk("msw_state", 32'(dut.state), 32'd0);

        // mixed program: counted loop, store/load, sltu, andi, jump over, end loop
        clear_prog();
        prog[0]  = i_op(9, 0, 1, 3);
        prog[1]  = i_op(9, 0, 2, 0);
        prog[2]  = r_op(2, 1, 2, 'h21);
        prog[3]  = i_op(9, 1, 1, -1);
        prog[4]  = i_op(5, 1, 0, -3);
        prog[5]  = i_op('h2B, 0, 2, 128);
        prog[6]  = i_op('h23, 0, 3, 128);
        prog[7]  = r_op(0, 3, 4, 'h2B);
        prog[8]  = i_op('h0C, 3, 5, 4);
        prog[9]  = j_op(11);
        prog[10] = i_op(9, 0, 6, 99);
        prog[11] = i_op(4, 0, 0, -1);
        boot();
        run(130);
        chk("mix_r1", dut.rf[1], 32'd0);
        chk("mix_r2", dut.rf[2], 32'd6);
        chk("mix_r3", dut.rf[3], 32'd6);
        chk("mix_r4", dut.rf[4], 32'd1);
        chk("mix_r5", dut.rf[5], 32'd4);
        chk("mix_r6", dut.rf[6], 32'd0);
        chk("mix_mem", mem_word(128), 32'd6);
        chk("mix_ir", dut.ir, 32'h1000_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
